// File: rtl/fetch_buffer.sv
// Circular PC/instruction queue between the fetch and decode stages.
// Optional macro FETCH_ADEL_EN enables fetch address-error tagging on push.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_adel,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   LAST     = PW'(DEPTH - 1);
  localparam logic [31:0]     RESET_PC = 32'h0000_3000;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   store_instr;

  // Initializers give the post-reset state before the first reset edge.
  logic [PW-1:0] wr_ptr = '0;
  logic [PW-1:0] rd_ptr = '0;
  logic [PW:0]   cnt_q  = '0;

  logic push;
  logic pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage carries no reset; discarded entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= store_instr;
    end
  end

`ifdef FETCH_ADEL_EN
  logic adel_mem [DEPTH];
  logic in_adel;

  assign in_adel     = (in_pc[1:0] != 2'b00) || (in_pc < RESET_PC) ||
                       (in_pc > 32'h0000_6FFC);
  assign store_instr = in_adel ? '0 : in_instr;

  always_ff @(posedge clk) begin
    if (push) adel_mem[wr_ptr] <= in_adel;
  end

  assign out_adel = out_valid && adel_mem[rd_ptr];
`else
  assign store_instr = in_instr;
  assign out_adel    = 1'b0;
`endif

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [31:0]            in_pc;
  logic [31:0]            in_instr;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic                   out_adel;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  entry_t q[$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] ins);
    entry_t e;
    e.pc    = pc;
    e.instr = ins;
    e.adel  = 1'b0;
`ifdef FETCH_ADEL_EN
    if ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6FFC) begin
      e.adel  = 1'b1;
      e.instr = 32'h0;
    end
`endif
    return e;
  endfunction

  task automatic check_outputs();
    check("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("count",     32'(count),     32'(q.size()));
    if (q.size() == 0) begin
      check("out_pc_idle",    out_pc,         32'h3000);
      check("out_instr_idle", out_instr,      32'h0);
      check("out_adel_idle",  32'(out_adel),  32'h0);
    end else begin
      check("out_pc",    out_pc,        q[0].pc);
      check("out_instr", out_instr,     q[0].instr);
      check("out_adel",  32'(out_adel), 32'(q[0].adel));
    end
  endtask

  // One clock cycle: apply inputs, compare pre-edge outputs, clock, update model.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit ordy, input bit fl, input bit rst);
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    check_outputs();
    do_push = iv && (q.size() != DEPTH);
    do_pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (!rst || fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(make_entry(pc, ins));
    end
    #1;
  endtask

  logic [31:0] adel_ins;
  logic [31:0] exp_adel [3];
  logic [31:0] exp_ins  [3];

  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0; reset = 0;

    step(0, 0, 0, 0, 0, 0);
    step(1, 32'h3000, 32'h1, 1, 0, 0);

    // Fill to DEPTH, then try a fifth push.
    for (int i = 0; i < 4; i++) step(1, 32'h3000 + 4 * i, $urandom, 0, 0, 1);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1, 32'h3010, $urandom, 0, 0, 1);
    check("fifth_ignored", 32'(count), 32'd4);

    // Full: pop with push offered; push must be refused.
    step(1, 32'h3014, $urandom, 1, 0, 1);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_head", out_pc, 32'h3004);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    step(1, 32'h3010, 32'hABCD_0001, 1, 0, 1);
    check("empty_push_pc", out_pc, 32'h3010);
    check("empty_push_valid", 32'(out_valid), 32'd1);

    step(1, 32'h3014, $urandom, 0, 0, 1);
    step(1, 32'h3018, $urandom, 0, 0, 1);
    step(1, 32'h3020, $urandom, 1, 1, 1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_pc", out_pc, 32'h3000);

    step(1, 32'h3100, $urandom, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 32'h3104 + 4 * i, $urandom, 1, 0, 1);
    step(1, 32'h3200, $urandom, 0, 0, 1);
    check("pre_reset_count", 32'(count), 32'd2);
    step(0, 0, 0, 0, 0, 0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_instr", out_instr, 32'h0);

    // Address-error tagging: misaligned, out of range, then legal.
    adel_ins = 32'h1234_5678;
    step(1, 32'h3002, 32'h1111_1111, 0, 0, 1);
    step(1, 32'h7000, 32'h2222_2222, 0, 0, 1);
    step(1, 32'h3004, adel_ins, 0, 0, 1);
`ifdef FETCH_ADEL_EN
    exp_adel = '{32'd1, 32'd1, 32'd0};
    exp_ins  = '{32'h0, 32'h0, adel_ins};
`else
    exp_adel = '{32'd0, 32'd0, 32'd0};
    exp_ins  = '{32'h1111_1111, 32'h2222_2222, adel_ins};
`endif
    for (int i = 0; i < 3; i++) begin
      check("adel_flag", 32'(out_adel), exp_adel[i]);
      check("adel_instr", out_instr, exp_ins[i]);
      step(0, 0, 0, 1, 0, 1);
    end

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                       : 32'h3000 + 32'(4 * $urandom_range(0, 4095));
      step($urandom_range(0, 9) < 7, pc, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 clears block on posedge clk).
REQ-004 SHALL have port in_valid  input  1  fetch stage presents a PC/instruction pair.
REQ-005 SHALL have port in_pc  input  32  address of fetched instruction, as produced by the PC register.
REQ-006 SHALL have port in_instr  input  32  instruction word read from IM at in_pc.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a push this cycle; drives PC register enable.
REQ-008 SHALL have port out_valid  output  1  head entry available to decode.
REQ-009 SHALL have port out_ready  input  1  decode consumes head entry this cycle.
REQ-010 SHALL have port out_pc  output  32  PC of head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of head entry.
REQ-012 SHALL have port out_adel  output  1  head entry carries a fetch address-error flag.
REQ-013 SHALL have port flush  input  1  discard all entries (branch/jump redirect).
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL store entries in a circular array with write pointer, read pointer, and count; pointers wrap DEPTH-1 -> 0.
REQ-016 SHALL drive in_ready = (count != DEPTH); push accepted when in_valid && in_ready.
REQ-017 SHALL drive out_valid = (count != 0); pop accepted when out_valid && out_ready.
REQ-018 SHALL write an accepted push into the entry at write pointer on the same posedge; the entry becomes visible at the head no earlier than the next cycle (no combinational in->out bypass).
REQ-019 SHALL drive out_pc/out_instr/out_adel combinationally from the entry at read pointer when out_valid=1.
REQ-020 SHALL drive out_pc=32'h0000_3000, out_instr=32'h0000_0000, out_adel=0 when out_valid=0.
REQ-021 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 When full, SHALL NOT accept a push even if a pop occurs the same cycle; in_ready depends only on registered count.
REQ-023 When empty, a push with out_ready=1 SHALL be accepted and SHALL NOT be popped that cycle.
REQ-024 flush=1 SHALL, on the next posedge, set count=0 and both pointers=0, discarding any same-cycle push and pop; flush has priority over push/pop.
REQ-025 in_ready and out_valid SHALL be unaffected by flush in the flush cycle itself (derived from registered count).
REQ-026 Push when full or pop when empty SHALL have no effect on any state.

Reset
REQ-027 reset==0 at posedge clk SHALL set count=0, both pointers=0; reset has priority over flush, push, and pop.
REQ-028 After reset: in_ready=1, out_valid=0, out_pc=32'h0000_3000, out_instr=0, out_adel=0.
REQ-029 reset asserted mid-operation SHALL discard all stored entries on that edge; entry contents need not be cleared.
REQ-030 An initial block SHALL put the same state as REQ-027 for simulation before the first reset edge.

Configuration
REQ-031 Macro FETCH_ADEL_EN SHALL select address-error checking on push.
REQ-032 With FETCH_ADEL_EN defined: a pushed entry SHALL have adel=1 and stored instr=32'h0000_0000 when in_pc[1:0]!=0, in_pc<32'h0000_3000, or in_pc>32'h0000_6FFC; otherwise adel=0 and instr=in_instr.
REQ-033 Without FETCH_ADEL_EN: out_adel SHALL be constant 0; instr stored unmodified; no adel storage.

Verification
REQ-034 Release reset, push PCs 0x3000,0x3004,0x3008,0x300C with out_ready=0 -> count=4, in_ready=0; fifth push ignored.
REQ-035 Full buffer, in_valid=1 and out_ready=1 for one cycle -> head 0x3000 popped, no push taken, count=3.
REQ-036 Empty buffer, push 0x3010 with out_ready=1 -> out_valid=0 that cycle; next cycle out_pc=0x3010, out_valid=1.
REQ-037 count=3, flush=1 with push and pop same cycle -> next cycle count=0, out_valid=0, out_pc=0x3000; 10 push/pop cycles then show wrap with correct order.
REQ-038 count=2, reset=0 one cycle -> count=0, in_ready=1, out_instr=0.
REQ-039 FETCH_ADEL_EN defined, push 0x3002 then 0x7000 then 0x3004 -> out_adel=1,1,0; out_instr=0,0,in_instr; macro undefined -> out_adel=0 for all.
